// File: rtl/mem_responder_if.sv
// Request/response bus between the processor memory port and mem_responder.
// The master side issues word requests; the slave side accepts them and
// returns a single-cycle response carrying read data or a fault flag.
interface mem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Slow-memory model for the multicycle processor's unified memory port.
// Accepts one request at a time, waits LATENCY cycles, performs the access
// against a 2^ADDR_W word array and pulses a response for one cycle.
// Misaligned or out-of-range addresses fault instead of touching the array.
module mem_responder #(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic              capture;
    logic              do_access;

    logic              cap_we;
    logic [31:0]       cap_addr;
    logic [31:0]       cap_wdata;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_fault;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    // State register; reset always parks the responder in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: decides when to capture a request, count wait states
    // and fire the memory access on the edge that enters RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = LAT4;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Access operands: a zero-latency access uses the live request because
    // it happens on the accept edge; otherwise the captured copy is used.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = cap_we;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
        end
    end

    assign acc_idx   = acc_addr[ADDR_W+1:2];
    assign acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);

    // Wait counter, request capture and the registered response fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (capture) begin
                cap_we    <= bus.req_we;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
            if (do_access) begin
                if (acc_fault) begin
                    err_q   <= 1'b1;
                    rdata_q <= 32'd0;
                end else begin
                    err_q   <= 1'b0;
                    rdata_q <= acc_we ? 32'd0 : mem[acc_idx];
                end
            end
        end
    end

    // Word array write port; contents survive reset and faulting writes are dropped.
    always_ff @(posedge clk) begin
        if (!reset && do_access && acc_we && !acc_fault) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
